box_detect: RTL and testbench
=============================

BOX_DETECT -- requirements
Module: box_detect

Interface
REQ-001 Parameter MIN_HITS, default 16: minimum hit pixels per frame for a box to count as valid.
REQ-002 Parameter CNT_W, default 20: width of the hit counter.
REQ-003 CLK  input  1  system clock; all logic is clocked on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 det_en  input  1  detector enable.
REQ-006 frame_start  input  1  one-cycle pulse marking the start of a frame.
REQ-007 frame_end  input  1  one-cycle pulse marking the end of a frame.
REQ-008 pix_valid  input  1  X, Y and hit are valid this cycle.
REQ-009 X  input  16  current pixel column.
REQ-010 Y  input  16  current pixel row.
REQ-011 hit  input  1  the current pixel matches the target mask.
REQ-012 x1  output  16  left edge of the last valid box.
REQ-013 y1  output  16  top edge of the last valid box.
REQ-014 x2  output  16  right edge of the last valid box.
REQ-015 y2  output  16  bottom edge of the last valid box.
REQ-016 box_valid  output  1  level; the last completed frame produced a valid box.
REQ-017 box_update  output  1  one-cycle pulse when a frame result is latched.
REQ-018 frame_hits  output  CNT_W  hit count of the last completed frame.

Function
REQ-019 The block SHALL use a three-state FSM: IDLE, SCAN, LATCH.
REQ-020 In IDLE, frame_start with det_en=1 SHALL move the FSM to SCAN and clear the accumulators.
  - Cleared accumulators: min_x=min_y=16'hFFFF, max_x=max_y=0, hit_cnt=0.
REQ-021 In SCAN, each cycle with pix_valid=1 and hit=1 SHALL update the accumulators.
  - min_x=min(min_x,X), max_x=max(max_x,X), min_y=min(min_y,Y), max_y=max(max_y,Y).
  - hit_cnt+1, saturating at 2^CNT_W-1.
  - Comparisons are unsigned 16-bit.
REQ-022 Pixels while in IDLE or LATCH, or with pix_valid=0, SHALL NOT change the accumulators.
REQ-023 In SCAN, frame_end SHALL move the FSM to LATCH, and a qualifying pixel on that same edge SHALL be accumulated.
REQ-024 In SCAN, frame_start without frame_end SHALL clear the accumulators and stay in SCAN (the partial frame is discarded, no box_update).
REQ-025 In SCAN, simultaneous frame_start and frame_end SHALL be treated as frame_end, and the frame_start SHALL be ignored.
REQ-026 In LATCH, the FSM SHALL register the frame result and return to IDLE after one cycle.
  - frame_hits <= hit_cnt.
  - box_update <= 1 for exactly one cycle.
  - If hit_cnt >= MIN_HITS: x1<=min_x, y1<=min_y, x2<=max_x, y2<=max_y, box_valid<=1.
  - Otherwise: box_valid<=0 and x1..y2 hold their previous values.
REQ-027 frame_start during LATCH SHALL still complete the latch from the pre-clear accumulator values, then go directly to SCAN with the accumulators cleared.
REQ-028 Latency SHALL be fixed.
  - frame_end is sampled at edge k.
  - Outputs and box_update become valid after edge k+1.
REQ-029 Guaranteed ordering SHALL hold whenever box_valid=1: x1<=x2 and y1<=y2.
REQ-030 det_en=0 SHALL force the FSM to IDLE on the next edge, abandon any in-progress frame without box_update, and leave the outputs unchanged.
REQ-031 frame_end in IDLE SHALL be ignored.
REQ-032 box_update SHALL be 0 in every cycle other than the one defined in REQ-026.

Reset
REQ-033 rst_n=0 at a clock edge SHALL apply the following, regardless of state or mid-frame activity:
  - FSM to IDLE.
  - x1=y1=x2=y2=0, box_valid=0, box_update=0, frame_hits=0.
  - min regs=16'hFFFF, max regs=0, hit_cnt=0.
REQ-034 After rst_n returns to 1, the block SHALL ignore pixels until the next frame_start.

Verification
REQ-035 Square frame: 20 hits spanning X 100..119 at Y=50, then frame_end -> two edges later x1=100, x2=119, y1=y2=50, box_valid=1, frame_hits=20, one box_update pulse.
REQ-036 Sparse frame: 10 hits (below MIN_HITS=16) after a valid box (10,20,30,40) -> box_valid=0, x1..y2 stay 10,20,30,40, frame_hits=10, box_update pulses once.
REQ-037 Restart: frame_start mid-SCAN after hits at X=5, then 16 hits at X=200..215, Y=7 -> x1=200, x2=215; X=5 excluded.
REQ-038 Boundary: the final hit at (65535,65535) on the frame_end edge plus 15 hits at (0,0) -> x1=y1=0, x2=y2=65535, frame_hits=16.
REQ-039 Back-to-back: frame_start during LATCH -> the first frame result is latched correctly, and the second frame accumulates from cleared state with no lost pixels after the LATCH cycle.
REQ-040 Reset mid-SCAN with 30 hits accumulated -> all outputs 0, no box_update, and the following frame with 16 hits at (3,4) gives box (3,4,3,4).

Source files
------------

// File: rtl/box_detect.sv
//==============================================================================
// Module   : box_detect
// Purpose  : Per-frame bounding box of hit pixels, with a minimum-hit qualifier.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module box_detect #(
    parameter int MIN_HITS = 16,
    parameter int CNT_W    = 20
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             det_en,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             pix_valid,
    input  logic [15:0]      X,
    input  logic [15:0]      Y,
    input  logic             hit,
    output logic [15:0]      x1,
    output logic [15:0]      y1,
    output logic [15:0]      x2,
    output logic [15:0]      y2,
    output logic             box_valid,
    output logic             box_update,
    output logic [CNT_W-1:0] frame_hits
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_min_hits = CNT_W'(MIN_HITS);

    state_t           r_state;
    logic [15:0]      r_min_x;
    logic [15:0]      r_min_y;
    logic [15:0]      r_max_x;
    logic [15:0]      r_max_y;
    logic [CNT_W-1:0] r_hit_cnt;

    logic             w_clear;
    logic             w_accum;
    logic [15:0]      w_min_x;
    logic [15:0]      w_min_y;
    logic [15:0]      w_max_x;
    logic [15:0]      w_max_y;
    logic [CNT_W-1:0] w_cnt_inc;

    // frame_end wins over a simultaneous frame_start while scanning
    always_comb begin
        w_clear = 1'b0;
        w_accum = 1'b0;
        if (det_en) begin
            case (r_state)
                ST_IDLE:  w_clear = frame_start;
                ST_SCAN: begin
                    w_clear = frame_start && !frame_end;
                    w_accum = pix_valid && hit && (frame_end || !frame_start);
                end
                ST_LATCH: w_clear = frame_start;
                default:  w_clear = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_min_x   = (X < r_min_x) ? X : r_min_x;
        w_min_y   = (Y < r_min_y) ? Y : r_min_y;
        w_max_x   = (X > r_max_x) ? X : r_max_x;
        w_max_y   = (Y > r_max_y) ? Y : r_max_y;
        w_cnt_inc = (r_hit_cnt == c_cnt_max) ? r_hit_cnt : r_hit_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            x1         <= '0;
            y1         <= '0;
            x2         <= '0;
            y2         <= '0;
            box_valid  <= 1'b0;
            box_update <= 1'b0;
            frame_hits <= '0;
        end else begin
            box_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (det_en && frame_start)
                        r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (!det_en)
                        r_state <= ST_IDLE;
                    else if (frame_end)
                        r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    if (!det_en) begin
                        r_state <= ST_IDLE;
                    end else begin
                        // Latch uses accumulator values from before any same-edge clear
                        frame_hits <= r_hit_cnt;
                        box_update <= 1'b1;
                        if (r_hit_cnt >= c_min_hits) begin
                            x1        <= r_min_x;
                            y1        <= r_min_y;
                            x2        <= r_max_x;
                            y2        <= r_max_y;
                            box_valid <= 1'b1;
                        end else begin
                            box_valid <= 1'b0;
                        end
                        r_state <= frame_start ? ST_SCAN : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n || w_clear) begin
            r_min_x   <= 16'hFFFF;
            r_min_y   <= 16'hFFFF;
            r_max_x   <= 16'h0000;
            r_max_y   <= 16'h0000;
            r_hit_cnt <= '0;
        end else if (w_accum) begin
            r_min_x   <= w_min_x;
            r_min_y   <= w_min_y;
            r_max_x   <= w_max_x;
            r_max_y   <= w_max_y;
            r_hit_cnt <= w_cnt_inc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_box_detect.sv
//==============================================================================
// Module   : tb_box_detect
// Purpose  : Directed self-checking bench for box_detect.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_box_detect;

    logic        CLK;
    logic        rst_n;
    logic        det_en;
    logic        frame_start;
    logic        frame_end;
    logic        pix_valid;
    logic [15:0] X;
    logic [15:0] Y;
    logic        hit;
    logic [15:0] x1, y1, x2, y2;
    logic        box_valid;
    logic        box_update;
    logic [19:0] frame_hits;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    box_detect #(.MIN_HITS(16), .CNT_W(20)) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .det_en     (det_en),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .pix_valid  (pix_valid),
        .X          (X),
        .Y          (Y),
        .hit        (hit),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .box_valid  (box_valid),
        .box_update (box_update),
        .frame_hits (frame_hits)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) if (box_update) upd_cnt++;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic pixel(input logic [15:0] px, input logic [15:0] py, input logic ph);
        pix_valid = 1'b1; X = px; Y = py; hit = ph;
        tick();
        pix_valid = 1'b0; hit = 1'b0;
    endtask

    task automatic start_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic check_box(input string tag, input logic [15:0] ex1, input logic [15:0] ey1,
                             input logic [15:0] ex2, input logic [15:0] ey2,
                             input logic ev, input logic [19:0] eh);
        check({tag, "_x1"}, 32'(x1), 32'(ex1));
        check({tag, "_y1"}, 32'(y1), 32'(ey1));
        check({tag, "_x2"}, 32'(x2), 32'(ex2));
        check({tag, "_y2"}, 32'(y2), 32'(ey2));
        check({tag, "_valid"}, 32'(box_valid), 32'(ev));
        check({tag, "_hits"}, 32'(frame_hits), 32'(eh));
    endtask

    // Drives frame_end (any pixel already set up goes with it), then checks the
    // one-cycle latch latency and a single box_update pulse.
    task automatic end_and_check(input string tag, input logic restart,
                                 input logic [15:0] ex1, input logic [15:0] ey1,
                                 input logic [15:0] ex2, input logic [15:0] ey2,
                                 input logic ev, input logic [19:0] eh);
        int u0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0; pix_valid = 1'b0; hit = 1'b0;
        u0 = upd_cnt;
        check({tag, "_upd_early"}, 32'(box_update), 32'd0);
        frame_start = restart;
        tick();
        frame_start = 1'b0;
        check({tag, "_upd"}, 32'(box_update), 32'd1);
        check_box(tag, ex1, ey1, ex2, ey2, ev, eh);
        if (!restart) begin
            tick();
            check({tag, "_upd_low"}, 32'(box_update), 32'd0);
            check({tag, "_upd_cnt"}, 32'(upd_cnt), 32'(u0 + 1));
        end
    endtask

    initial begin
        int u;
        rst_n = 1'b0; det_en = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        pix_valid = 1'b0; X = '0; Y = '0; hit = 1'b0;
        tick(); tick();
        check("rst_upd", 32'(box_update), 32'd0);
        check_box("rst", 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 20'd0);
        rst_n = 1'b1; det_en = 1'b1;

        // Square frame, plus non-qualifying pixels that must be ignored
        pixel(16'd1, 16'd1, 1'b1);
        start_frame();
        pixel(16'd5, 16'd5, 1'b0);
        X = 16'd900; Y = 16'd900; hit = 1'b1; tick(); hit = 1'b0;
        for (int i = 0; i < 20; i++) pixel(16'(100 + i), 16'd50, 1'b1);
        end_and_check("square", 1'b0, 16'd100, 16'd50, 16'd119, 16'd50, 1'b1, 20'd20);

        // Valid box (10,20,30,40) followed by a sparse frame
        start_frame();
        for (int i = 0; i < 8; i++) begin
            pixel(16'd10, 16'd20, 1'b1);
            pixel(16'd30, 16'd40, 1'b1);
        end
        end_and_check("box", 1'b0, 16'd10, 16'd20, 16'd30, 16'd40, 1'b1, 20'd16);
        start_frame();
        for (int i = 0; i < 10; i++) pixel(16'd500, 16'd500, 1'b1);
        end_and_check("sparse", 1'b0, 16'd10, 16'd20, 16'd30, 16'd40, 1'b0, 20'd10);

        // Restart mid-scan discards X=5
        u = upd_cnt;
        start_frame();
        pixel(16'd5, 16'd7, 1'b1);
        start_frame();
        check("restart_no_upd", 32'(upd_cnt), 32'(u));
        for (int i = 0; i < 16; i++) pixel(16'(200 + i), 16'd7, 1'b1);
        end_and_check("restart", 1'b0, 16'd200, 16'd7, 16'd215, 16'd7, 1'b1, 20'd16);

        // Extreme coordinates, last hit on the frame_end edge
        start_frame();
        for (int i = 0; i < 15; i++) pixel(16'd0, 16'd0, 1'b1);
        pix_valid = 1'b1; X = 16'hFFFF; Y = 16'hFFFF; hit = 1'b1;
        end_and_check("bound", 1'b0, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 1'b1, 20'd16);

        // Back-to-back: frame_start during LATCH, next frame starts immediately
        start_frame();
        for (int i = 0; i < 16; i++) pixel(16'(1000 + i), 16'd9, 1'b1);
        end_and_check("b2b_a", 1'b1, 16'd1000, 16'd9, 16'd1015, 16'd9, 1'b1, 20'd16);
        for (int i = 0; i < 16; i++) pixel(16'(40 + i), 16'd60, 1'b1);
        end_and_check("b2b_b", 1'b0, 16'd40, 16'd60, 16'd55, 16'd60, 1'b1, 20'd16);

        // det_en drop abandons the frame; a later frame_end in IDLE is ignored
        u = upd_cnt;
        start_frame();
        for (int i = 0; i < 20; i++) pixel(16'd2, 16'd2, 1'b1);
        det_en = 1'b0; tick(); det_en = 1'b1;
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        tick(); tick();
        check("dis_no_upd", 32'(upd_cnt), 32'(u));
        check_box("dis", 16'd40, 16'd60, 16'd55, 16'd60, 1'b1, 20'd16);

        // Reset mid-scan, then pixels before frame_start must be ignored
        start_frame();
        for (int i = 0; i < 30; i++) pixel(16'd7, 16'd7, 1'b1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        u = upd_cnt;
        check("rst2_upd", 32'(box_update), 32'd0);
        check_box("rst2", 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 20'd0);
        pixel(16'd9999, 16'd9999, 1'b1);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        tick(); tick();
        check("rst2_no_upd", 32'(upd_cnt), 32'(u));
        start_frame();
        for (int i = 0; i < 16; i++) pixel(16'd3, 16'd4, 1'b1);
        end_and_check("post_rst", 1'b0, 16'd3, 16'd4, 16'd3, 16'd4, 1'b1, 20'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
